mitchell_antilog: RTL and testbench
===================================

MITCHELL_ANTILOG -- requirements
Module: mitchell_antilog

Interface
REQ-001 Parameter DATA_WIDTH, default 16: linear output width in bits.
REQ-002 Parameter FRAC_W, default 8: fractional bits of the log-domain input.
REQ-003 Parameter INT_W, default 5: integer (characteristic) bits of the log-domain input; width of k.
REQ-004 The module SHALL have a single clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  input word present.
REQ-008 in_ready  out  1  block accepts the input word this cycle.
REQ-009 in_log  in  INT_W+FRAC_W  unsigned log2 value {k, f}: k in the upper INT_W bits, f in the lower FRAC_W bits.
REQ-010 in_zero  in  1  the linear source was zero; the result SHALL be 0 regardless of in_log.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 out_data  out  DATA_WIDTH  linear approximation of 2^in_log.
REQ-014 out_sat  out  1  out_data was clamped; qualified by out_valid.
REQ-015 sat_count  out  16  number of saturated results transferred.
REQ-016 sat_count_clr  in  1  synchronous clear of sat_count.

Function
REQ-017 Transfer rules: input transfers on in_valid && in_ready; output transfers on out_valid && out_ready.
REQ-018 Arithmetic: mantissa m = 2^FRAC_W + f, width FRAC_W+1.
REQ-019 Arithmetic for k >= FRAC_W: result = m << (k - FRAC_W).
REQ-020 Arithmetic for k < FRAC_W: result = (m + 2^(FRAC_W-k-1)) >> (FRAC_W - k), rounding half up.
REQ-021 Saturation: if k >= DATA_WIDTH, or the rounded result is >= 2^DATA_WIDTH, then out_data = all ones and out_sat = 1; otherwise out_sat = 0.
REQ-022 Zero input: in_zero = 1 SHALL give out_data = 0 and out_sat = 0.
REQ-023 Pipeline: two register stages. S1 registers k, m and the zero flag; S2 registers the shifted, rounded and saturated result.
REQ-024 Latency: exactly 2 cycles from input transfer to out_valid when not stalled.
REQ-025 Throughput: one result per cycle while out_ready = 1.
REQ-026 Advance rules: S2 loads when !s2_valid || out_ready. S1 loads when !s1_valid || S2 loads.
REQ-027 in_ready = !s1_valid || S2 loads, so pipeline bubbles collapse.
REQ-028 in_ready SHALL NOT depend combinationally on in_valid.
REQ-029 Stall: while out_valid && !out_ready, out_data and out_sat SHALL hold stable.
REQ-030 Stall: no accepted word SHALL be lost or duplicated.
REQ-031 sat_count increments by 1 on each output transfer with out_sat = 1.
REQ-032 sat_count saturates at 0xFFFF.
REQ-033 sat_count_clr has priority over an increment in the same cycle; the result is 0.
REQ-034 Behaviour is fully defined for all in_log values, including k = 0, f = 0, and k = 2^INT_W - 1.

Reset
REQ-035 rst SHALL clear s1_valid, s2_valid and out_valid.
REQ-036 Reset values: out_data = 0, out_sat = 0, sat_count = 0, in_ready = 1 in the cycle after reset.
REQ-037 rst asserted mid-operation SHALL discard all in-flight words.
REQ-038 No output transfer SHALL occur in the reset cycle.

Structure
REQ-039 Shared package agc_pkg SHALL hold the default DATA_WIDTH, FRAC_W and INT_W constants.
REQ-040 agc_pkg SHALL also hold a typedef for the {k, f} log word, shared with the log (encode) path.
REQ-041 One sub-module, mitchell_antilog_shift, SHALL hold the S1-to-S2 combinational logic: bidirectional shift, rounding and saturation.
REQ-042 Handshake and counter logic SHALL stay in the top level.

Verification (DATA_WIDTH=16, FRAC_W=8, INT_W=5)
REQ-043 in_log=0x0D3F -> out_data=0x27E0, out_sat=0, two cycles later.
REQ-044 in_log=0x0380 -> 0x000C; in_log=0x00C0 -> 0x0002 (rounding).
REQ-045 in_log=0x0FFF -> 0xFF80, sat=0; in_log=0x1000 -> 0xFFFF, sat=1; sat_count becomes 1; sat_count_clr -> 0.
REQ-046 in_zero=1 with in_log=0x1FFF -> out_data=0x0000, out_sat=0.
REQ-047 Backpressure: stream 8 words with random out_ready -> all 8 results in order, none dropped; out_data stable during stalls; in_ready falls only when both stages are full and out_ready=0.
REQ-048 Reset mid-stream: assert rst with 2 words in flight -> out_valid=0 the next cycle, no stale result emitted afterwards, sat_count=0.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared constants and the {k, f} log-word type for the log/antilog paths.
package agc_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned FRAC_W_DEF     = 8;
  localparam int unsigned INT_W_DEF      = 5;
  localparam int unsigned LOG_W_DEF      = INT_W_DEF + FRAC_W_DEF;

  // Log-domain word: characteristic k over fraction f.
  typedef struct packed {
    logic [INT_W_DEF-1:0]  k;
    logic [FRAC_W_DEF-1:0] f;
  } log_word_t;

endpackage

// File: rtl/mitchell_antilog_shift.sv
// Combinational core: shifts the mantissa by k, rounds half up on right
// shifts and clamps to all ones when the result does not fit.
module mitchell_antilog_shift
  import agc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FRAC_W     = FRAC_W_DEF,
  parameter int unsigned INT_W      = INT_W_DEF
) (
  input  logic [INT_W-1:0]      k,
  input  logic [FRAC_W:0]       m,
  input  logic                  zero,
  output logic [DATA_WIDTH-1:0] data_c,
  output logic                  sat_c
);

  localparam int unsigned UP_W = DATA_WIDTH + FRAC_W + 1;
  localparam int unsigned DN_W = FRAC_W + 2;

  int unsigned     k_int;
  logic [DN_W-1:0] dn_sum;
  logic [DN_W-1:0] dn_val;
  logic [UP_W-1:0] res;
  logic            overflow;

  always_comb begin
    k_int    = 32'(k);
    dn_sum   = '0;
    dn_val   = '0;
    res      = '0;
    overflow = 1'b0;
    if (k_int >= DATA_WIDTH) begin
      overflow = 1'b1;
    end else if (k_int >= FRAC_W) begin
      res = UP_W'(m) << (k_int - FRAC_W);
    end else begin
      // Add half an output LSB before truncating: round half up.
      dn_sum = DN_W'(m) + (DN_W'(1) << (FRAC_W - k_int - 1));
      dn_val = dn_sum >> (FRAC_W - k_int);
      res    = UP_W'(dn_val);
    end
    if (res[UP_W-1:DATA_WIDTH] != '0) begin
      overflow = 1'b1;
    end
    if (zero) begin
      data_c = '0;
      sat_c  = 1'b0;
    end else if (overflow) begin
      data_c = '1;
      sat_c  = 1'b1;
    end else begin
      data_c = res[DATA_WIDTH-1:0];
      sat_c  = 1'b0;
    end
  end

endmodule

// File: rtl/mitchell_antilog.sv
// Two-stage valid/ready pipeline converting a Mitchell log2 word {k, f}
// back to a saturated linear value, with a saturation event counter.
module mitchell_antilog
  import agc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FRAC_W     = FRAC_W_DEF,
  parameter int unsigned INT_W      = INT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INT_W+FRAC_W-1:0] in_log,
  input  logic                    in_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_sat,
  output logic [15:0]             sat_count,
  input  logic                    sat_count_clr
);

  localparam int unsigned LOG_W = INT_W + FRAC_W;
  localparam int unsigned CNT_W = 16;

  logic                  s1_valid_q, s1_valid_d;
  logic [INT_W-1:0]      s1_k_q, s1_k_d;
  logic [FRAC_W:0]       s1_m_q, s1_m_d;
  logic                  s1_zero_q, s1_zero_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                  s2_sat_q, s2_sat_d;
  logic [CNT_W-1:0]      sat_count_q, sat_count_d;

  logic                  s1_load_c;
  logic                  s2_load_c;
  logic                  out_xfer_c;
  logic [DATA_WIDTH-1:0] shift_data_c;
  logic                  shift_sat_c;

  mitchell_antilog_shift #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_W     (FRAC_W),
    .INT_W      (INT_W)
  ) u_shift (
    .k      (s1_k_q),
    .m      (s1_m_q),
    .zero   (s1_zero_q),
    .data_c (shift_data_c),
    .sat_c  (shift_sat_c)
  );

  // Stage advance, data capture and saturation counter next-state.
  always_comb begin
    s2_load_c   = !s2_valid_q || out_ready;
    s1_load_c   = !s1_valid_q || s2_load_c;
    out_xfer_c  = s2_valid_q && out_ready;
    s1_valid_d  = s1_valid_q;
    s1_k_d      = s1_k_q;
    s1_m_d      = s1_m_q;
    s1_zero_d   = s1_zero_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_sat_d    = s2_sat_q;
    sat_count_d = sat_count_q;

    if (s1_load_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_k_d    = in_log[LOG_W-1:FRAC_W];
        s1_m_d    = {1'b1, in_log[FRAC_W-1:0]};
        s1_zero_d = in_zero;
      end
    end

    // Bubbles leave the last result in place so out_data stays quiet.
    if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = shift_data_c;
        s2_sat_d  = shift_sat_c;
      end
    end

    if (sat_count_clr) begin
      sat_count_d = '0;
    end else if (out_xfer_c && s2_sat_q && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_k_q      <= '0;
      s1_m_q      <= '0;
      s1_zero_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_sat_q    <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_k_q      <= s1_k_d;
      s1_m_q      <= s1_m_d;
      s1_zero_q   <= s1_zero_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_sat_q    <= s2_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign in_ready  = s1_load_c;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_mitchell_antilog.sv
// Scoreboard bench for mitchell_antilog: table vectors, backpressure and
// reset/counter corner sequences.
module tb_mitchell_antilog;
  import agc_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
  } exp_t;

  typedef struct {
    log_word_t   lg;
    logic        zero;
    logic [15:0] data;
    logic        sat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] in_log = '0;
  logic        in_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_sat;
  logic [15:0] sat_count;
  logic        sat_count_clr = 1'b0;

  logic [15:0] cur_exp_d = '0;
  logic        cur_exp_s = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        sb_q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  logic        prev_sat   = 1'b0;

  mitchell_antilog dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_log        (in_log),
    .in_zero       (in_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_sat       (out_sat),
    .sat_count     (sat_count),
    .sat_count_clr (sat_count_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [12:0] lg, input logic z);
    exp_t            e;
    int unsigned     k;
    longint unsigned m;
    longint unsigned r;
    k = 32'(lg[12:8]);
    m = 64'd256 + 64'(lg[7:0]);
    if (k >= 8) r = m << (k - 8);
    else        r = (m + (64'd1 << (7 - k))) >> (8 - k);
    if (z) begin
      e.d = 16'h0000; e.s = 1'b0;
    end else if (k >= 16 || r >= 64'd65536) begin
      e.d = 16'hFFFF; e.s = 1'b1;
    end else begin
      e.d = r[15:0];  e.s = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: handshake checks, output pops, input pushes.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(!(sb_q.size() == 2 && !out_ready)));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", {15'd0, out_sat, out_data}, {15'd0, prev_sat, prev_data});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_sat", 32'(out_sat), 32'(e.s));
        end
      end
      if (in_valid && in_ready) sb_q.push_back({cur_exp_d, cur_exp_s});
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sat   = out_sat;
    end
  end

  // Present one word from posedge+1 and return at posedge+1 after it transfers.
  task automatic send(input logic [12:0] lg, input logic z, input logic [15:0] ed,
                      input logic es, input logic rnd_ready);
    bit accepted;
    in_valid  = 1'b1;
    in_log    = lg;
    in_zero   = z;
    cur_exp_d = ed;
    cur_exp_s = es;
    accepted  = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    if (!accepted) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    exp_t e;
    bit   seen;

    vecs[0]  = '{13'h0D3F, 1'b0, 16'h27E0, 1'b0};
    vecs[1]  = '{13'h0380, 1'b0, 16'h000C, 1'b0};
    vecs[2]  = '{13'h00C0, 1'b0, 16'h0002, 1'b0};
    vecs[3]  = '{13'h0FFF, 1'b0, 16'hFF80, 1'b0};
    vecs[4]  = '{13'h1000, 1'b0, 16'hFFFF, 1'b1};
    vecs[5]  = '{13'h1FFF, 1'b1, 16'h0000, 1'b0};
    vecs[6]  = '{13'h1FFF, 1'b0, 16'hFFFF, 1'b1};
    vecs[7]  = '{13'h0000, 1'b0, 16'h0001, 1'b0};
    vecs[8]  = '{13'h0800, 1'b0, 16'h0100, 1'b0};
    vecs[9]  = '{13'h0700, 1'b0, 16'h0080, 1'b0};
    vecs[10] = '{13'h00FF, 1'b0, 16'h0002, 1'b0};
    vecs[11] = '{13'h0E00, 1'b0, 16'h4000, 1'b0};

    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: result appears on the second edge after the transfer.
    @(posedge clk);
    #1;
    send(13'h0D3F, 1'b0, 16'h27E0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_cycle2_data", 32'(out_data), 32'h27E0);
    @(posedge clk);
    #1;

    // Table vectors, back to back.
    foreach (vecs[i]) send(vecs[i].lg, vecs[i].zero, vecs[i].data, vecs[i].sat, 1'b0);
    drain();
    check("sat_count_table", 32'(sat_count), 32'd2);

    sat_count_clr = 1'b1;
    @(posedge clk);
    #1 sat_count_clr = 1'b0;
    @(negedge clk);
    check("sat_count_clr", 32'(sat_count), 32'd0);

    // Clear wins over a saturated transfer in the same cycle.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(13'h1000, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1 seen = out_valid;
    end
    check("clr_prio_valid", 32'(seen), 32'd1);
    out_ready     = 1'b1;
    sat_count_clr = 1'b1;
    @(posedge clk);
    #1 sat_count_clr = 1'b0;
    @(negedge clk);
    check("clr_priority", 32'(sat_count), 32'd0);

    // A lone saturated transfer increments by one.
    @(posedge clk);
    #1;
    send(13'h1A55, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    drain();
    check("sat_count_inc", 32'(sat_count), 32'd1);

    // Backpressure with random words and random out_ready.
    for (int i = 0; i < 8; i++) begin
      logic [12:0] w;
      logic        z;
      w = 13'($urandom_range(0, 8191));
      z = ($urandom_range(0, 7) == 0);
      e = model(w, z);
      send(w, z, e.d, e.s, 1'b1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(13'h1100, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    send(13'h0900, 1'b0, 16'h0200, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sat_count", 32'(sat_count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_stale", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

endmodule
